// File: rtl/dpot_responder_if.sv
// Signal bundle between an SPI initiator and the Pmod DPOT responder model.
// The initiator drives the serial link and error clear; the responder reports wiper state.
interface dpot_responder_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             nCS;
    logic             MOSI;
    logic             err_clr;
    logic [WIDTH-1:0] wiper;
    logic             wiper_valid;
    logic             busy;
    logic [CNT_W-1:0] frame_cnt;
    logic             short_err;
    logic             long_err;

    modport master (
        output nCS, MOSI, err_clr,
        input  wiper, wiper_valid, busy, frame_cnt, short_err, long_err
    );

    modport slave (
        input  nCS, MOSI, err_clr,
        output wiper, wiper_valid, busy, frame_cnt, short_err, long_err
    );
endinterface

// File: rtl/dpot_responder.sv
// SPI responder model of the Pmod DPOT: assembles MSB-first words on SCLK and
// commits each complete word to the wiper, flagging short and overlong frames.
module dpot_responder #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = 8'h80,
    parameter int               CNT_W       = 8
) (
    input logic              SCLK,
    input logic              rst,
    dpot_responder_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {SYNC, IDLE, SHIFT, HOLD} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_wiper;
    logic [CW-1:0]    r_cnt;
    logic             r_valid;
    logic             r_busy;
    logic [CNT_W-1:0] r_frame_cnt;
    logic             r_short;
    logic             r_long;

    logic [WIDTH-1:0] w_word;
    logic             w_last;

    assign w_word = {r_shift[WIDTH-2:0], bus.MOSI};
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge SCLK or posedge rst) begin
        if (rst) begin
            r_state     <= SYNC;
            r_shift     <= '0;
            r_wiper     <= RESET_VALUE;
            r_cnt       <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_cnt <= '0;
            r_short     <= 1'b0;
            r_long      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (bus.nCS) begin
                r_cnt <= '0;
            end
            // Clear first so that an error raised on this same edge overrides it
            if (bus.err_clr) begin
                r_short <= 1'b0;
                r_long  <= 1'b0;
            end
            case (r_state)
                SYNC: begin
                    r_busy <= 1'b0;
                    if (bus.nCS) begin
                        r_state <= IDLE;
                    end
                end
                IDLE: begin
                    if (!bus.nCS) begin
                        r_shift <= w_word;
                        r_cnt   <= CW'(1);
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!bus.nCS) begin
                        r_shift <= w_word;
                        r_cnt   <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_wiper     <= w_word;
                            r_valid     <= 1'b1;
                            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                            r_state     <= HOLD;
                        end
                    end else begin
                        r_short <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                HOLD: begin
                    // Extra bits after a complete word are dropped; the commit stands
                    if (bus.nCS) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_long <= 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= SYNC;
                end
            endcase
        end
    end

    assign bus.wiper       = r_wiper;
    assign bus.wiper_valid = r_valid;
    assign bus.busy        = r_busy;
    assign bus.frame_cnt   = r_frame_cnt;
    assign bus.short_err   = r_short;
    assign bus.long_err    = r_long;
endmodule

// File: tb/tb_dpot_responder.sv
// Bench for dpot_responder: random and directed SPI frames checked against a
// frame-level model of wiper, frame count, pulse count and sticky error flags.
module tb_dpot_responder;
    logic SCLK = 1'b0;
    logic rst  = 1'b1;

    dpot_responder_if #(.WIDTH(8), .CNT_W(8)) bus ();

    dpot_responder #(.WIDTH(8), .RESET_VALUE(8'h80), .CNT_W(8)) dut (
        .SCLK (SCLK),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 SCLK = ~SCLK;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    always @(negedge SCLK) if (bus.wiper_valid === 1'b1) pulses++;

    // Frame-level reference model
    logic [7:0] m_wiper;
    int         m_cnt;
    int         m_pulses = 0;
    bit         m_short, m_long;

    function automatic void model_reset();
        m_wiper = 8'h80; m_cnt = 0; m_short = 0; m_long = 0;
    endfunction

    function automatic void model_frame(input logic [15:0] data, input int n, input bit clr);
        if (n >= 8) begin
            m_wiper = 8'(data >> (n - 8));
            m_cnt = (m_cnt + 1) % 256;
            m_pulses++;
        end
        if (n > 8) m_long = 1;
        if (clr) begin m_short = 0; m_long = 0; end
        if (n > 0 && n < 8) m_short = 1;
    endfunction

    // Observations captured while a frame is clocked in
    logic [7:0] obs_lsb_wiper;
    logic       obs_lsb_valid, obs_after_valid, obs_busy_mid, obs_busy_end;

    task automatic send_frame(input logic [15:0] data, input int n, input bit clr);
        obs_lsb_wiper = 'x; obs_lsb_valid = 'x; obs_after_valid = 'x; obs_busy_mid = 'x;
        for (int i = 0; i < n; i++) begin
            @(negedge SCLK);
            bus.nCS = 1'b0; bus.err_clr = 1'b0; bus.MOSI = data[n-1-i];
            @(posedge SCLK); #1;
            if (i == 0) obs_busy_mid = bus.busy;
            if (i == 7) begin obs_lsb_wiper = bus.wiper; obs_lsb_valid = bus.wiper_valid; end
            if (i == 8) obs_after_valid = bus.wiper_valid;
        end
        @(negedge SCLK);
        bus.nCS = 1'b1; bus.err_clr = clr; bus.MOSI = 1'($urandom);
        @(posedge SCLK); #1;
        obs_busy_end = bus.busy;
        if (n == 8) obs_after_valid = bus.wiper_valid;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge SCLK);
            bus.nCS = 1'b1; bus.err_clr = 1'b0; bus.MOSI = 1'($urandom);
        end
        @(posedge SCLK); #1;
    endtask

    task automatic do_reset();
        @(negedge SCLK);
        rst = 1'b1; bus.nCS = 1'b1; bus.err_clr = 1'b0;
        repeat (2) @(negedge SCLK);
        rst = 1'b0;
        model_reset();
        idle(2);
    endtask

    task automatic test_reset();
        bus.nCS = 1'b1; bus.MOSI = 1'b0; bus.err_clr = 1'b0; rst = 1'b1;
        model_reset();
        repeat (3) @(negedge SCLK);
        checks++; if (bus.wiper !== 8'h80) begin failures++; $display("FAIL reset_wiper_in_rst got=%0h exp=80", bus.wiper); end
        rst = 1'b0;
        idle(3);
        checks++; if (bus.wiper !== 8'h80) begin failures++; $display("FAIL reset_wiper got=%0h exp=80", bus.wiper); end
        checks++; if (bus.wiper_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus.wiper_valid); end
        checks++; if (bus.frame_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bus.frame_cnt); end
        checks++; if (bus.short_err !== 1'b0 || bus.long_err !== 1'b0) begin failures++; $display("FAIL reset_errs got=%b%b exp=00", bus.short_err, bus.long_err); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    endtask

    task automatic test_single();
        model_frame(16'h00A5, 8, 0);
        send_frame(16'h00A5, 8, 0);
        checks++; if (obs_lsb_wiper !== 8'hA5) begin failures++; $display("FAIL single_latency_wiper got=%0h exp=a5", obs_lsb_wiper); end
        checks++; if (obs_lsb_valid !== 1'b1) begin failures++; $display("FAIL single_pulse got=%0b exp=1", obs_lsb_valid); end
        checks++; if (obs_after_valid !== 1'b0) begin failures++; $display("FAIL single_pulse_width got=%0b exp=0", obs_after_valid); end
        checks++; if (obs_busy_mid !== 1'b1 || obs_busy_end !== 1'b0) begin failures++; $display("FAIL single_busy got=%b%b exp=10", obs_busy_mid, obs_busy_end); end
        checks++; if (bus.frame_cnt !== 8'(m_cnt)) begin failures++; $display("FAIL single_cnt got=%0d exp=%0d", bus.frame_cnt, m_cnt); end
        checks++; if (pulses !== m_pulses) begin failures++; $display("FAIL single_pulses got=%0d exp=%0d", pulses, m_pulses); end
    endtask

    task automatic test_back_to_back();
        model_frame(16'h0000, 8, 0);
        send_frame(16'h0000, 8, 0);
        checks++; if (obs_lsb_wiper !== 8'h00) begin failures++; $display("FAIL b2b_first got=%0h exp=00", obs_lsb_wiper); end
        model_frame(16'h00FF, 8, 0);
        send_frame(16'h00FF, 8, 0);
        checks++; if (bus.wiper !== 8'hFF) begin failures++; $display("FAIL b2b_wiper got=%0h exp=ff", bus.wiper); end
        checks++; if (bus.frame_cnt !== 8'(m_cnt)) begin failures++; $display("FAIL b2b_cnt got=%0d exp=%0d", bus.frame_cnt, m_cnt); end
        checks++; if (pulses !== m_pulses) begin failures++; $display("FAIL b2b_pulses got=%0d exp=%0d", pulses, m_pulses); end
        checks++; if (bus.short_err !== 1'b0 || bus.long_err !== 1'b0) begin failures++; $display("FAIL b2b_errs got=%b%b exp=00", bus.short_err, bus.long_err); end
    endtask

    task automatic test_short();
        model_frame(16'h0007, 5, 0);
        send_frame(16'h0007, 5, 0);
        checks++; if (bus.short_err !== 1'b1) begin failures++; $display("FAIL short_flag got=%0b exp=1", bus.short_err); end
        checks++; if (bus.wiper !== m_wiper) begin failures++; $display("FAIL short_wiper got=%0h exp=%0h", bus.wiper, m_wiper); end
        checks++; if (bus.frame_cnt !== 8'(m_cnt)) begin failures++; $display("FAIL short_cnt got=%0d exp=%0d", bus.frame_cnt, m_cnt); end
        @(negedge SCLK); bus.err_clr = 1'b1;
        @(posedge SCLK); #1;
        m_short = 0; m_long = 0;
        checks++; if (bus.short_err !== 1'b0) begin failures++; $display("FAIL short_clear got=%0b exp=0", bus.short_err); end
        checks++; if (bus.frame_cnt !== 8'(m_cnt)) begin failures++; $display("FAIL clear_keeps_cnt got=%0d exp=%0d", bus.frame_cnt, m_cnt); end
        idle(1);
    endtask

    task automatic test_long();
        model_frame(16'h016B, 10, 0);
        send_frame(16'h016B, 10, 0);
        checks++; if (bus.wiper !== 8'h5A) begin failures++; $display("FAIL long_wiper got=%0h exp=5a", bus.wiper); end
        checks++; if (obs_after_valid !== 1'b0) begin failures++; $display("FAIL long_second_pulse got=%0b exp=0", obs_after_valid); end
        checks++; if (bus.long_err !== 1'b1) begin failures++; $display("FAIL long_flag got=%0b exp=1", bus.long_err); end
        checks++; if (bus.frame_cnt !== 8'(m_cnt)) begin failures++; $display("FAIL long_cnt got=%0d exp=%0d", bus.frame_cnt, m_cnt); end
        checks++; if (pulses !== m_pulses) begin failures++; $display("FAIL long_pulses got=%0d exp=%0d", pulses, m_pulses); end
    endtask

    task automatic test_reset_midframe();
        int p0;
        for (int i = 0; i < 3; i++) begin
            @(negedge SCLK); bus.nCS = 1'b0; bus.err_clr = 1'b0; bus.MOSI = 1'($urandom);
        end
        @(negedge SCLK); rst = 1'b1; #1;
        model_reset();
        checks++; if (bus.wiper !== 8'h80 || bus.long_err !== 1'b0) begin failures++; $display("FAIL async_reset got=%0h/%0b exp=80/0", bus.wiper, bus.long_err); end
        @(negedge SCLK); rst = 1'b0;
        p0 = pulses;
        for (int i = 0; i < 5; i++) begin
            @(negedge SCLK); bus.nCS = 1'b0; bus.MOSI = 1'($urandom);
        end
        @(posedge SCLK); #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL sync_busy got=%0b exp=0", bus.busy); end
        checks++; if (pulses !== p0 || bus.wiper !== 8'h80) begin failures++; $display("FAIL sync_discard got=%0d/%0h exp=%0d/80", pulses, bus.wiper, p0); end
        idle(1);
        model_frame(16'h0012, 8, 0);
        send_frame(16'h0012, 8, 0);
        checks++; if (bus.wiper !== 8'h12) begin failures++; $display("FAIL resync_wiper got=%0h exp=12", bus.wiper); end
        checks++; if (bus.frame_cnt !== 8'(m_cnt)) begin failures++; $display("FAIL resync_cnt got=%0d exp=%0d", bus.frame_cnt, m_cnt); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            logic [15:0] d;
            int          n;
            bit          c;
            d = 16'($urandom);
            n = $urandom_range(1, 11);
            c = ($urandom_range(0, 3) == 0);
            model_frame(d, n, c);
            send_frame(d, n, c);
            checks++; if (bus.wiper !== m_wiper) begin failures++; $display("FAIL rand_wiper k=%0d n=%0d got=%0h exp=%0h", k, n, bus.wiper, m_wiper); end
            checks++; if (bus.frame_cnt !== 8'(m_cnt)) begin failures++; $display("FAIL rand_cnt k=%0d got=%0d exp=%0d", k, bus.frame_cnt, m_cnt); end
            checks++; if (bus.short_err !== m_short || bus.long_err !== m_long) begin failures++; $display("FAIL rand_errs k=%0d n=%0d got=%b%b exp=%b%b", k, n, bus.short_err, bus.long_err, m_short, m_long); end
            checks++; if (pulses !== m_pulses) begin failures++; $display("FAIL rand_pulses k=%0d got=%0d exp=%0d", k, pulses, m_pulses); end
            if (n >= 8) begin
                checks++; if (obs_lsb_valid !== 1'b1 || obs_after_valid !== 1'b0) begin failures++; $display("FAIL rand_pulse_shape k=%0d got=%b%b exp=10", k, obs_lsb_valid, obs_after_valid); end
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 256; k++) begin
            logic [15:0] d;
            d = 16'($urandom_range(0, 255));
            model_frame(d, 8, 0);
            send_frame(d, 8, 0);
        end
        checks++; if (bus.frame_cnt !== 8'd0) begin failures++; $display("FAIL wrap_cnt got=%0d exp=0", bus.frame_cnt); end
        checks++; if (bus.wiper !== m_wiper) begin failures++; $display("FAIL wrap_wiper got=%0h exp=%0h", bus.wiper, m_wiper); end
        checks++; if (pulses !== m_pulses) begin failures++; $display("FAIL wrap_pulses got=%0d exp=%0d", pulses, m_pulses); end
        model_frame(16'h0005, 3, 1);
        send_frame(16'h0005, 3, 1);
        checks++; if (bus.short_err !== 1'b1) begin failures++; $display("FAIL err_beats_clr got=%0b exp=1", bus.short_err); end
        checks++; if (bus.frame_cnt !== 8'(m_cnt)) begin failures++; $display("FAIL err_clr_cnt got=%0d exp=%0d", bus.frame_cnt, m_cnt); end
        idle(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_short();
        test_long();
        test_reset_midframe();
        test_random();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
